rot_issue: RTL and testbench

Issue-and-collect stage for the ALU's 4-bit rotate-right unit. It accepts rotate commands over a valid/ready handshake and normalises left rotations into equivalent right amounts. It drives the rotate-right unit's `data`/`select` inputs from registers and captures the unit's combinational result into an output FIFO. A sweep mode issues all four rotations of one operand back-to-back, which the bench and the ALU self-check path use.

---
 rtl/rot_issue.sv | 115 +++++++++++
 tb/tb_rot_issue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rot_issue.sv
// Issue/collect stage for the 4-bit rotate-right unit: normalises commands to right
// amounts, drives the unit from registers and queues its results in a small FIFO.
module rot_issue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [1:0] in_amt,
  input  logic       in_dir,
  input  logic       in_sweep,
  output logic [3:0] rot_data,
  output logic [1:0] rot_select,
  input  logic [3:0] rot_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [1:0] out_amt,
  output logic       out_last,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic [3:0] data;
    logic [1:0] amt;
    logic       last;
  } ent_t;

  state_t        state, state_nx;
  logic [3:0]    op_data;
  logic [1:0]    cur_amt, step;
  logic          sweep;
  ent_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          accept, push, pop, full, last;
  ent_t          head;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign full     = (count == FULL_CNT);
  assign last     = !sweep || (step == 2'd3);
  // full is judged on the pre-pop count, so a full FIFO blocks the push even if it pops
  assign push     = (state == ISSUE) && !full;
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;
  assign busy     = (state != IDLE) || out_valid;

  // the operand/amount registers feed the unit directly, so they hold while idle
  assign rot_data   = op_data;
  assign rot_select = cur_amt;

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head.data : 4'd0;
  assign out_amt  = out_valid ? head.amt  : 2'd0;
  assign out_last = out_valid && head.last;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   if (push && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_data <= '0;
      cur_amt <= '0;
      step    <= '0;
      sweep   <= 1'b0;
    end else if (accept) begin
      op_data <= in_data;
      sweep   <= in_sweep;
      // a left rotation by n is a right rotation by (4-n) mod 4
      cur_amt <= in_dir ? 2'(2'd0 - in_amt) : in_amt;
      step    <= '0;
    end else if (push && !last) begin
      step    <= step + 2'd1;
      cur_amt <= cur_amt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: rot_out, amt: cur_amt, last: last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_rot_issue.sv
// Randomised bench for rot_issue: a queue-based model of pending and queued results
// is compared cycle by cycle against the handshake and FIFO outputs.
module tb_rot_issue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_dir, in_sweep;
  logic [3:0] in_data;
  logic [1:0] in_amt;
  logic [3:0] rot_data, rot_out;
  logic [1:0] rot_select;
  logic       out_valid, out_ready, out_last, busy;
  logic [3:0] out_data;
  logic [1:0] out_amt;

  always #5 clk = ~clk;

  rot_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_dir(in_dir), .in_sweep(in_sweep),
    .rot_data(rot_data), .rot_select(rot_select), .rot_out(rot_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_amt(out_amt), .out_last(out_last), .busy(busy)
  );

  // combinational rotate-right unit
  function automatic logic [3:0] unit_rotr(input logic [3:0] d, input logic [1:0] a);
    logic [7:0] t;
    t = {d, d} >> a;
    return t[3:0];
  endfunction
  assign rot_out = unit_rotr(rot_data, rot_select);

  // reference rotation: move the LSB to the top, a times
  function automatic logic [3:0] ref_rotr(input logic [3:0] d, input int a);
    logic [3:0] r;
    r = d;
    for (int i = 0; i < a; i++) r = {r[0], r[3:1]};
    return r;
  endfunction

  typedef struct {
    logic [3:0] d;
    logic [1:0] a;
    logic       l;
  } res_t;

  res_t       pendq[$];   // accepted but not yet pushed
  res_t       fifoq[$];   // pushed, awaiting pop
  logic [3:0] mdl_data;
  logic [1:0] mdl_sel;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock: check outputs at negedge, drive inputs, advance the model past the next edge
  task automatic cyc(input logic v, input logic [3:0] d, input logic [1:0] a,
                     input logic dr, input logic sw, input logic ordy);
    bit acc, pop, push;
    int eff, n;
    res_t e;
    @(negedge clk);
    chk("in_ready", in_ready, pendq.size() == 0);
    chk("out_valid", out_valid, fifoq.size() > 0);
    chk("busy", busy, (pendq.size() + fifoq.size()) > 0);
    chk("rot_select", rot_select, mdl_sel);
    chk("rot_data", rot_data, mdl_data);
    if (fifoq.size() > 0) begin
      chk("out_data", out_data, fifoq[0].d);
      chk("out_amt", out_amt, fifoq[0].a);
      chk("out_last", out_last, fifoq[0].l);
    end
    in_valid = v; in_data = d; in_amt = a; in_dir = dr; in_sweep = sw; out_ready = ordy;
    acc  = v && (pendq.size() == 0);
    pop  = (fifoq.size() > 0) && ordy;
    push = (pendq.size() > 0) && (fifoq.size() < DEPTH);
    if (pop)  void'(fifoq.pop_front());
    if (push) fifoq.push_back(pendq.pop_front());
    if (acc) begin
      eff = dr ? (4 - int'(a)) % 4 : int'(a);
      n   = sw ? 4 : 1;
      for (int k = 0; k < n; k++) begin
        e.a = 2'((eff + k) % 4);
        e.d = ref_rotr(d, (eff + k) % 4);
        e.l = (k == n - 1);
        pendq.push_back(e);
      end
      mdl_data = d;
    end
    if (pendq.size() > 0) mdl_sel = pendq[0].a;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst rot_data", rot_data, 4'd0);
    chk("rst rot_select", rot_select, 2'd0);
    chk("rst out_data", {out_data, out_amt, out_last}, 7'd0);
    pendq.delete(); fifoq.delete();
    mdl_data = '0; mdl_sel = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_amt = 0; in_dir = 0; in_sweep = 0;
    out_ready = 0; mdl_data = '0; mdl_sel = '0;
    #3;
    chk("por in_ready", in_ready, 1'b1);
    chk("por busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // right single, left single, left by 0
    cyc(1, 4'b1000, 2'd1, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 4'b1000, 2'd1, 1, 0, 1); cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 4'b1000, 2'd0, 1, 0, 1); cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    // sweep with consumer always ready; valid held to show no accept during ISSUE
    cyc(1, 4'b1011, 2'd2, 0, 1, 1);
    repeat (6) cyc(1, 4'b0110, 2'd3, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    // backpressure: fill the FIFO, stall a single, then drain one at a time and freely
    cyc(1, 4'b0001, 2'd0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 4'b0010, 2'd1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0, 1);
    // reset mid-sweep after two results pushed
    cyc(1, 4'b1101, 2'd1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 4'b0110, 2'd1, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);

    // random traffic with bursts of backpressure
    for (int i = 0; i < 3000; i++) begin
      logic ordy;
      ordy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 2) == 0, 4'($urandom), 2'($urandom), 1'($urandom),
          $urandom_range(0, 3) == 0, ordy);
      if (i == 1500) do_reset();
    end
    repeat (20) cyc(0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
